exp_scale_stage: RTL and testbench

- Final stage of the exponential datapath: takes the Taylor-series result e^r (unsigned fixed point) and the range-reduction exponent k, and produces e^x = e^r * 2^k in output fixed-point format.
- Sits directly downstream of the Taylor stage-2 control/datapath; its in_valid is driven by that stage's output_ready pulse.
- Iterative log-step shifter: one shift stage per cycle, fixed latency, with saturation/underflow flags and a valid/ready output handshake.

---
 rtl/exp_scale_stage_pkg.sv | 21 ++
 rtl/exp_scale_shift_step.sv | 45 ++++
 rtl/exp_scale_stage.sv | 188 ++++++++++++++++++
 tb/tb_exp_scale_stage.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/exp_scale_stage_pkg.sv
// Shared constants and state encoding for the exponential scale stage.
// Default widths describe a Q2.30 Taylor mantissa scaled into a Q16.16 result.
package exp_pkg;

    localparam int DEF_IN_W     = 32;
    localparam int DEF_IN_FRAC  = 30;
    localparam int DEF_K_W      = 8;
    localparam int DEF_OUT_W    = 32;
    localparam int DEF_OUT_FRAC = 16;
    localparam int DEF_SH_BITS  = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // 1.0 in the input Q2.30 format
    localparam logic [DEF_IN_W-1:0] ONE_IN = 32'h4000_0000;

endpackage

// File: rtl/exp_scale_shift_step.sv
// One log-step of the iterative shifter: shifts the work register by 2^stage
// when amt_bit is set, and reports 1 bits pushed out of the top on left shifts.
module exp_scale_shift_step
    import exp_pkg::*;
#(
    parameter int W     = DEF_IN_W + DEF_OUT_W,
    parameter int N_STG = DEF_SH_BITS,
    parameter int STG_W = $clog2(DEF_SH_BITS)
) (
    input  logic [W-1:0]     work_in,
    input  logic             dir_left,
    input  logic             amt_bit,
    input  logic [STG_W-1:0] stage,
    output logic [W-1:0]     work_out,
    output logic             ovf_bit
);

    localparam logic [W-1:0] ONES = '1;

    logic [W-1:0] sh_l;
    logic [W-1:0] sh_r;
    logic [W-1:0] lost;

    always_comb begin
        sh_l = work_in;
        sh_r = work_in;
        lost = '0;
        for (int i = 0; i < N_STG; i++) begin
            if (stage == STG_W'(i)) begin
                sh_l = work_in << (1 << i);
                sh_r = work_in >> (1 << i);
                // bits that a left shift of this size pushes past the MSB
                lost = work_in & ~(ONES >> (1 << i));
            end
        end

        work_out = work_in;
        ovf_bit  = 1'b0;
        if (amt_bit) begin
            work_out = dir_left ? sh_l : sh_r;
            ovf_bit  = dir_left & (|lost);
        end
    end

endmodule

// File: rtl/exp_scale_stage.sv
// Scales e^r by 2^k into the output fixed-point format using one log-step
// shift per cycle, giving a fixed latency with saturation/underflow flags.
module exp_scale_stage
    import exp_pkg::*;
#(
    parameter int IN_W     = DEF_IN_W,
    parameter int IN_FRAC  = DEF_IN_FRAC,
    parameter int K_W      = DEF_K_W,
    parameter int OUT_W    = DEF_OUT_W,
    parameter int OUT_FRAC = DEF_OUT_FRAC,
    parameter int SH_BITS  = DEF_SH_BITS
) (
    input  logic             CLK,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_mant,
    input  logic [K_W-1:0]   in_k,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_ovf,
    output logic             out_unf
);

    localparam int SW = K_W + 2;
    localparam int WW = IN_W + OUT_W;
    localparam int CW = $clog2(SH_BITS);

    // Handshake: a transfer happens on a rising CLK edge where valid and ready
    // are both high; valid never drops before that edge, and data stays stable.

    state_t             state_q, state_d;
    logic [WW-1:0]      work_q, work_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [SH_BITS-1:0] mag_q, mag_d;
    logic               dir_q, dir_d;
    logic               ovf_q, ovf_d;
    logic               zf_q, zf_d;
    logic               nz_q, nz_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic [OUT_W-1:0]   out_data_q, out_data_d;
    logic               out_ovf_q, out_ovf_d;
    logic               out_unf_q, out_unf_d;

    logic [SW-1:0]      s_w;
    logic [SW-1:0]      s_mag;
    logic               s_big;
    logic [WW-1:0]      step_work;
    logic               step_ovf;
    logic               ovf_fin;
    logic [OUT_W-1:0]   res_fin;

    // Effective shift s = k + OUT_FRAC - IN_FRAC, taken as sign and magnitude
    always_comb begin
        s_w   = {{(SW-K_W){in_k[K_W-1]}}, in_k} + SW'(OUT_FRAC) - SW'(IN_FRAC);
        s_mag = s_w[SW-1] ? (~s_w + SW'(1)) : s_w;
        s_big = |s_mag[SW-1:SH_BITS];
    end

    exp_scale_shift_step #(
        .W     (WW),
        .N_STG (SH_BITS),
        .STG_W (CW)
    ) u_step (
        .work_in  (work_q),
        .dir_left (dir_q),
        .amt_bit  (mag_q[cnt_q]),
        .stage    (cnt_q),
        .work_out (step_work),
        .ovf_bit  (step_ovf)
    );

    // The integer result sits in the upper OUT_W bits of the work register;
    // the lower bits keep fraction bits from right shifts and are truncated.
    assign res_fin = step_work[WW-1 -: OUT_W];
    assign ovf_fin = ovf_q | step_ovf;

    always_comb begin
        state_d     = state_q;
        work_d      = work_q;
        cnt_d       = cnt_q;
        mag_d       = mag_q;
        dir_d       = dir_q;
        ovf_d       = ovf_q;
        zf_d        = zf_q;
        nz_d        = nz_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ovf_d   = out_ovf_q;
        out_unf_d   = out_unf_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    work_d     = {in_mant, {OUT_W{1'b0}}};
                    dir_d      = ~s_w[SW-1];
                    mag_d      = s_mag[SH_BITS-1:0];
                    nz_d       = |in_mant;
                    // shifts beyond the shifter's reach are settled up front;
                    // a zero mantissa stays an exact zero whatever k is
                    ovf_d      = s_big & ~s_w[SW-1] & (|in_mant);
                    zf_d       = s_big & s_w[SW-1];
                    cnt_d      = '0;
                    in_ready_d = 1'b0;
                    state_d    = SHIFT;
                end
            end

            SHIFT: begin
                work_d = step_work;
                ovf_d  = ovf_fin;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CW'(SH_BITS - 1)) begin
                    cnt_d       = '0;
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    out_ovf_d   = ovf_fin;
                    if (ovf_fin) begin
                        out_data_d = '1;
                        out_unf_d  = 1'b0;
                    end else if (zf_q) begin
                        out_data_d = '0;
                        out_unf_d  = nz_q;
                    end else begin
                        out_data_d = res_fin;
                        out_unf_d  = nz_q & (res_fin == '0);
                    end
                end
            end

            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end

            default: begin
                state_d     = IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            work_q      <= '0;
            cnt_q       <= '0;
            mag_q       <= '0;
            dir_q       <= 1'b0;
            ovf_q       <= 1'b0;
            zf_q        <= 1'b0;
            nz_q        <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ovf_q   <= 1'b0;
            out_unf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            work_q      <= work_d;
            cnt_q       <= cnt_d;
            mag_q       <= mag_d;
            dir_q       <= dir_d;
            ovf_q       <= ovf_d;
            zf_q        <= zf_d;
            nz_q        <= nz_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ovf_q   <= out_ovf_d;
            out_unf_q   <= out_unf_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ovf   = out_ovf_q;
    assign out_unf   = out_unf_q;

endmodule

// File: tb/tb_exp_scale_stage.sv
// Bench for exp_scale_stage: table vectors, random transactions against an
// arithmetic model, backpressure and mid-operation reset sequences.
module tb_exp_scale_stage;
    import exp_pkg::*;

    logic        CLK;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_mant;
    logic [7:0]  in_k;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_ovf;
    logic        out_unf;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    exp_scale_stage dut (
        .CLK       (CLK),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mant   (in_mant),
        .in_k      (in_k),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ovf   (out_ovf),
        .out_unf   (out_unf)
    );

    // clock / reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    // e^x = floor(m * 2^s), s = k - 14, saturating to 32 bits
    function automatic void model(input logic [31:0] m, input logic [7:0] k,
                                  output logic [31:0] d, output logic o, output logic u);
        int s;
        logic [63:0] v;
        s = int'($signed(k)) + 16 - 30;
        d = 32'h0;
        o = 1'b0;
        u = 1'b0;
        if (m == 32'h0) return;
        if (s >= 0) begin
            if (s >= 32) o = 1'b1;
            else begin
                v = {32'h0, m} << s;
                if (v[63:32] != 32'h0) o = 1'b1;
                else d = v[31:0];
            end
        end else if (-s < 32) begin
            d = m >> (-s);
        end
        if (o) d = 32'hFFFF_FFFF;
        u = !o && (d == 32'h0);
    endfunction

    task automatic wait_ready(input string tag);
        int w;
        w = 0;
        while (!in_ready && w < 20) begin
            @(posedge CLK); #1;
            w++;
        end
        check({tag, "_in_ready"}, in_ready, 1);
    endtask

    task automatic wait_valid(input string tag, output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge CLK); #1;
            lat++;
        end
        check({tag, "_latency"}, lat, 6);
    endtask

    // driver + compare for one full transaction; expected data comes from exp_q
    task automatic do_txn(input string tag, input logic [31:0] m, input logic [7:0] k,
                          input logic eo, input logic eu);
        int lat;
        wait_ready(tag);
        in_mant  = m;
        in_k     = k;
        in_valid = 1'b1;
        @(posedge CLK); #1;
        in_valid = 1'b0;
        check({tag, "_busy"}, in_ready, 0);
        wait_valid(tag, lat);
        check({tag, "_data"}, out_data, exp_q.pop_front());
        check({tag, "_ovf"}, out_ovf, eo);
        check({tag, "_unf"}, out_unf, eu);
        out_ready = 1'b1;
        @(posedge CLK); #1;
        out_ready = 1'b0;
        check({tag, "_consumed"}, out_valid, 0);
    endtask

    typedef struct {
        logic [31:0] mant;
        logic [7:0]  k;
        logic [31:0] d;
        logic        o;
        logic        u;
    } vec_t;

    vec_t vecs[14];

    initial begin
        logic [31:0] ed;
        logic        eo, eu;
        int          lat;

        vecs[0]  = '{ONE_IN,       8'd0,   32'h0001_0000, 1'b0, 1'b0};
        vecs[1]  = '{32'h6000_0000, 8'hFF, 32'h0000_C000, 1'b0, 1'b0};
        vecs[2]  = '{ONE_IN,       8'd3,   32'h0008_0000, 1'b0, 1'b0};
        vecs[3]  = '{ONE_IN,       8'd20,  32'hFFFF_FFFF, 1'b1, 1'b0};
        vecs[4]  = '{ONE_IN,       8'd127, 32'hFFFF_FFFF, 1'b1, 1'b0};
        vecs[5]  = '{ONE_IN,       8'hEC,  32'h0000_0000, 1'b0, 1'b1};
        vecs[6]  = '{32'h0,        8'd5,   32'h0000_0000, 1'b0, 1'b0};
        vecs[7]  = '{32'h0,        8'd127, 32'h0000_0000, 1'b0, 1'b0};
        vecs[8]  = '{32'h1234_5678, 8'd14, 32'h1234_5678, 1'b0, 1'b0};
        vecs[9]  = '{32'hFFFF_FFFF, 8'd14, 32'hFFFF_FFFF, 1'b0, 1'b0};
        vecs[10] = '{32'hFFFF_FFFF, 8'h80, 32'h0000_0000, 1'b0, 1'b1};
        vecs[11] = '{32'h1,        8'd45,  32'h8000_0000, 1'b0, 1'b0};
        vecs[12] = '{32'h2,        8'd45,  32'hFFFF_FFFF, 1'b1, 1'b0};
        vecs[13] = '{32'h0000_8001, 8'hFF, 32'h0000_0001, 1'b0, 1'b0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_mant   = 32'h0;
        in_k      = 8'h0;
        repeat (2) @(posedge CLK);
        #1;
        rst = 1'b0;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_ovf", out_ovf, 0);
        check("rst_out_unf", out_unf, 0);

        for (int i = 0; i < 14; i++) begin
            exp_q.push_back(vecs[i].d);
            do_txn($sformatf("vec%0d", i), vecs[i].mant, vecs[i].k, vecs[i].o, vecs[i].u);
        end

        // backpressure: 1.5 * 2^2 = 6.0 held for three cycles in DONE
        wait_ready("bp");
        in_mant  = 32'h6000_0000;
        in_k     = 8'd2;
        in_valid = 1'b1;
        @(posedge CLK); #1;
        in_valid = 1'b0;
        wait_valid("bp", lat);
        for (int c = 0; c < 3; c++) begin
            in_mant  = ONE_IN;
            in_k     = 8'd0;
            in_valid = 1'b1;
            @(posedge CLK); #1;
            check("bp_hold_valid", out_valid, 1);
            check("bp_hold_data", out_data, 32'h0006_0000);
            check("bp_hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge CLK); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("bp_release_valid", out_valid, 0);
        check("bp_same_cycle_not_taken", in_ready, 1);
        exp_q.push_back(32'h0000_C000);
        do_txn("bp_next", 32'h6000_0000, 8'hFF, 1'b0, 1'b0);

        // reset while shifting at cnt=3
        wait_ready("mid");
        in_mant  = ONE_IN;
        in_k     = 8'd3;
        in_valid = 1'b1;
        @(posedge CLK); #1;
        in_valid = 1'b0;
        repeat (3) begin
            @(posedge CLK); #1;
        end
        rst = 1'b1;
        #1;
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_out_data", out_data, 0);
        check("mid_rst_out_ovf", out_ovf, 0);
        check("mid_rst_out_unf", out_unf, 0);
        @(posedge CLK); #1;
        rst = 1'b0;
        exp_q.push_back(32'h0001_0000);
        do_txn("post_rst", ONE_IN, 8'd0, 1'b0, 1'b0);

        // random transactions against the arithmetic model
        for (int n = 0; n < 150; n++) begin
            logic [31:0] m;
            logic [7:0]  k;
            case ($urandom_range(0, 3))
                0:       m = 32'h0;
                1:       m = 32'($urandom_range(1, 255));
                default: m = $urandom;
            endcase
            if ($urandom_range(0, 3) == 0) k = 8'($urandom_range(0, 255));
            else k = 8'($signed($urandom_range(0, 70)) - 35);
            model(m, k, ed, eo, eu);
            exp_q.push_back(ed);
            do_txn($sformatf("rnd%0d", n), m, k, eo, eu);
        end

        check("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
